// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and the parity helper.
// Both the buffered transmitter and the future receiver use this package.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Payloads narrower than 9 bits are zero-extended; the extra zeros do not
  // change the XOR, so one helper covers every legal DATA_BITS.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: parity_bit = p;
      PAR_ODD:  parity_bit = ~p;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with occupancy count. Reads are taken from the head
// register combinationally so a pop and its data are available in one cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and are sent
// as start / data (LSB first) / optional parity / stop framed characters.
// The line output is registered, so tx follows the FSM state by one cycle.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int             DIVISOR   = CLK_HZ / BAUD;
  localparam int             BW        = $clog2(DIVISOR);
  localparam logic [BW-1:0]  BAUD_LOAD = BW'(DIVISOR - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0]     PAR_MODE  = 2'(PARITY);

  uart_state_e            state_r, state_s;
  logic [BW-1:0]          baud_r, baud_s;
  logic [3:0]             bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0]   shift_r, shift_s;
  logic                   par_r, par_s;
  logic                   tx_r;
  logic                   busy_r;
  logic                   rst_done_r;
  logic                   line_s;
  logic                   bit_end_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [DATA_BITS-1:0]   fifo_head_s;

  // Ready is held low until the first edge out of reset, then reflects the
  // registered FIFO occupancy only.
  assign tx_ready  = rst_done_r && !fifo_full_s;
  assign push_s    = tx_valid && tx_ready;
  assign bit_end_s = (baud_r == {BW{1'b0}});
  assign tx        = tx_r;
  assign busy      = busy_r;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (tx_data),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  // Next-state, datapath updates and line level for the current state.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    par_s     = par_r;
    pop_s     = 1'b0;
    line_s    = 1'b1;
    case (state_r)
      ST_IDLE: begin
        line_s = 1'b1;
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_s   = fifo_head_s;
          par_s     = parity_bit(9'(fifo_head_s), PAR_MODE);
          bit_cnt_s = 4'd0;
          baud_s    = BAUD_LOAD;
          state_s   = ST_START;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_START: begin
        line_s = 1'b0;
        if (bit_end_s) begin
          baud_s    = BAUD_LOAD;
          bit_cnt_s = 4'd0;
          state_s   = ST_DATA;
        end else begin
          baud_s    = baud_r - BW'(1);
        end
      end
      ST_DATA: begin
        line_s = shift_r[0];
        if (bit_end_s) begin
          baud_s  = BAUD_LOAD;
          shift_s = shift_r >> 1;
          if (bit_cnt_r == LAST_DATA) begin
            bit_cnt_s = 4'd0;
            if (PAR_MODE != PAR_NONE) begin
              state_s = ST_PAR;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          baud_s = baud_r - BW'(1);
        end
      end
      ST_PAR: begin
        line_s = par_r;
        if (bit_end_s) begin
          baud_s    = BAUD_LOAD;
          bit_cnt_s = 4'd0;
          state_s   = ST_STOP;
        end else begin
          baud_s    = baud_r - BW'(1);
        end
      end
      ST_STOP: begin
        line_s = 1'b1;
        if (bit_end_s) begin
          baud_s = BAUD_LOAD;
          if (bit_cnt_r == LAST_STOP) begin
            bit_cnt_s = 4'd0;
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty_s) begin
              pop_s   = 1'b1;
              shift_s = fifo_head_s;
              par_s   = parity_bit(9'(fifo_head_s), PAR_MODE);
              state_s = ST_START;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          baud_s = baud_r - BW'(1);
        end
      end
      default: begin
        line_s  = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      baud_r     <= {BW{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      rst_done_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      tx_r       <= line_s;
      busy_r     <= (state_s != ST_IDLE);
      rst_done_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at DIVISOR=4: 8N1, 8E1, 8O1 and 7N2 instances.
module tb_uart_tx_buffered;

  logic       clk;
  logic       rst;
  logic [3:0] v_w;
  logic [7:0] d_a, d_e, d_o;
  logic [6:0] d_s;
  logic [3:0] tx_w, busy_w, ready_w;
  logic [2:0] cnt_w [4];

  int         errors;
  int         checks;
  int         acc, f, pos;
  logic       rdy_prev, bad;
  logic [7:0] word;
  logic [9:0] fw;

  uart_tx_buffered #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(d_a), .tx_valid(v_w[0]), .tx_ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_buffered #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(d_e), .tx_valid(v_w[1]), .tx_ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_buffered #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(d_o), .tx_valid(v_w[2]), .tx_ready(ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

  uart_tx_buffered #(.CLK_HZ(16), .BAUD(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(d_s), .tx_valid(v_w[3]), .tx_ready(ready_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [8:0] w);
    case (idx)
      0: d_a = w[7:0];
      1: d_e = w[7:0];
      2: d_o = w[7:0];
      3: d_s = w[6:0];
      default: d_a = w[7:0];
    endcase
  endtask

  // Push one word into an idle instance; returns at the negedge after the accepting edge.
  task automatic push_one(input int idx, input logic [8:0] w);
    chk("push_ready", 32'(ready_w[idx]), 32'd1);
    set_word(idx, w);
    v_w[idx] = 1'b1;
    tick();
    v_w[idx] = 1'b0;
    chk("push_count", 32'(cnt_w[idx]), 32'd1);
    chk("push_busy0", 32'(busy_w[idx]), 32'd0);
    chk("push_tx_idle", 32'(tx_w[idx]), 32'd1);
  endtask

  // lv[i] is the expected line level of bit-slot i (slot 0 = start bit).
  task automatic check_frame(input int idx, input logic [15:0] lv, input int n, input string tag);
    tick();
    chk({tag, "_lat_tx"}, 32'(tx_w[idx]), 32'd1);
    chk({tag, "_busy1"}, 32'(busy_w[idx]), 32'd1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        chk({tag, "_bit"}, 32'(tx_w[idx]), 32'(lv[i]));
      end
    end
    chk({tag, "_busy_fall"}, 32'(busy_w[idx]), 32'd0);
    tick();
    chk({tag, "_idle_tx"}, 32'(tx_w[idx]), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy_w[idx]), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    v_w    = 4'hF;
    d_a    = 8'h00;
    d_e    = 8'h00;
    d_o    = 8'h00;
    d_s    = 7'h00;

    // Reset with tx_valid high and data 0x00: nothing may be queued.
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chk("rst_tx", 32'(tx_w[k]), 32'd1);
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_count", 32'(cnt_w[k]), 32'd0);
      chk("rst_ready", 32'(ready_w[k]), 32'd0);
    end
    v_w = 4'h0;
    tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_ready", 32'(ready_w[k]), 32'd1);
      chk("post_rst_count", 32'(cnt_w[k]), 32'd0);
      chk("post_rst_tx", 32'(tx_w[k]), 32'd1);
    end

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    push_one(0, 9'h055);
    check_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, "8n1_55");

    // 8E1 0x07: three ones -> even parity bit 1
    push_one(1, 9'h007);
    check_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "8e1_07");

    // 8O1 0x07: odd parity bit 0
    push_one(2, 9'h007);
    check_frame(2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "8o1_07");

    // 7N2 0x41: 0,1,0,0,0,0,0,1,1,1
    push_one(3, 9'h041);
    check_frame(3, {6'b0, 2'b11, 7'h41, 1'b0}, 10, "7n2_41");

    // Burst 0x01..0x06 with tx_valid held high; c counts edges after the first accept.
    acc      = 0;
    word     = 8'd1;
    d_a      = word;
    v_w[0]   = 1'b1;
    for (int c = 0; c < 244; c++) begin
      rdy_prev = ready_w[0];
      tick();
      if (v_w[0] && rdy_prev) begin
        acc++;
        if (acc == 6) begin
          v_w[0] = 1'b0;
        end else begin
          word = word + 8'd1;
          d_a  = word;
        end
      end
      if (c == 1) chk("burst_push_pop_same_edge", 32'(cnt_w[0]), 32'd1);
      if (c == 4) begin
        chk("burst_full_count", 32'(cnt_w[0]), 32'd4);
        chk("burst_full_ready", 32'(ready_w[0]), 32'd0);
        chk("burst_acc5", 32'(acc), 32'd5);
      end
      if (c == 40) begin
        chk("burst_stall_ready", 32'(ready_w[0]), 32'd0);
        chk("burst_stall_acc", 32'(acc), 32'd5);
      end
      if (c == 41) begin
        chk("burst_slot_ready", 32'(ready_w[0]), 32'd1);
        chk("burst_slot_count", 32'(cnt_w[0]), 32'd3);
      end
      if (c == 42) chk("burst_acc6", 32'(acc), 32'd6);
      if (c >= 2 && c <= 241) begin
        f   = (c - 2) / 40;
        pos = (c - 2) % 40;
        fw  = {1'b1, 8'(f + 1), 1'b0};
        chk("burst_tx", 32'(tx_w[0]), 32'(fw[pos / 4]));
      end
      if (c == 240) chk("burst_busy_hold", 32'(busy_w[0]), 32'd1);
      if (c == 241) chk("burst_busy_fall", 32'(busy_w[0]), 32'd0);
      if (c == 242) chk("burst_idle_tx", 32'(tx_w[0]), 32'd1);
    end

    // Mid-frame reset: 0xA5 then 0x3C queued, reset during bit 1 of 0xA5.
    d_a    = 8'hA5;
    v_w[0] = 1'b1;
    tick();
    d_a    = 8'h3C;
    tick();
    v_w[0] = 1'b0;
    chk("mid_rst_queued", 32'(cnt_w[0]), 32'd1);
    repeat (12) tick();
    chk("mid_rst_bit1_low", 32'(tx_w[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("mid_rst_count", 32'(cnt_w[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    chk("mid_rst_ready", 32'(ready_w[0]), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready_back", 32'(ready_w[0]), 32'd1);
    chk("mid_rst_count_back", 32'(cnt_w[0]), 32'd0);
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (tx_w[0] !== 1'b1) bad = 1'b1;
    end
    chk("mid_rst_no_3c", 32'(bad), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy_w[0]), 32'd0);
    push_one(0, 9'h0A5);
    check_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "post_rst_a5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
